// File: rtl/waveform_loader.sv
// waveform_loader
// Writer side of the 512 x 24-bit waveform RAM used by the oscillator.
// After a start request it takes bytes from the UART receiver over a
// valid/ready handshake. It packs each group of three bytes, little-endian,
// into one sample and writes the samples to RAM port A at addresses
// 0..DEPTH-1. At the end it pulses done. A timeout or an abort pulses error.
//
// Ports
//   clk_in          system clock
//   rst_in          asynchronous active-high reset
//   start_in        begin loading a table (honoured only when idle)
//   abort_in        abandon the current load
//   byte_valid_in   byte_in carries a valid byte
//   byte_in         stream byte
//   byte_ready_out  a byte can be accepted this cycle
//   wr_en_out       RAM port A write enable (wea/ena)
//   wr_addr_out     RAM port A address
//   wr_data_out     RAM port A data
//   busy_out        a load is in progress
//   done_out        one-cycle pulse after the final sample is written
//   error_out       one-cycle pulse on timeout or abort
module waveform_loader #(
  parameter int DEPTH          = 512,
  parameter int ADDR_WIDTH     = 9,
  parameter int SAMPLE_WIDTH   = 24,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic                    byte_valid_in,
  input  logic [7:0]              byte_in,
  output logic                    byte_ready_out,
  output logic                    wr_en_out,
  output logic [ADDR_WIDTH-1:0]   wr_addr_out,
  output logic [SAMPLE_WIDTH-1:0] wr_data_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    error_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [1:0]              idx;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic [CNT_W-1:0]        idle_cnt;
  logic                    error_q;
  logic                    error_set;
  logic                    accept;

  // All outputs are decoded from flops, so an asynchronous reset
  // clears them at once.
  assign byte_ready_out = (state == COLLECT);
  assign accept         = byte_valid_in & byte_ready_out;
  assign wr_en_out      = (state == WRITE);
  assign wr_addr_out    = addr;
  assign wr_data_out    = sample;
  assign busy_out       = (state == COLLECT) || (state == WRITE);
  assign done_out       = (state == DONE);
  assign error_out      = error_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Priority inside COLLECT: abort, then an accepted byte, then timeout.
  // A byte that arrives on the last allowed cycle therefore still counts.
  always_comb begin
    state_next = state;
    error_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) state_next = COLLECT;
      end
      COLLECT: begin
        if (abort_in) begin
          state_next = IDLE;
          error_set  = 1'b1;
        end else if (accept) begin
          if (idx == 2'd2) state_next = WRITE;
        end else if (idle_cnt == CNT_LAST) begin
          state_next = IDLE;
          error_set  = 1'b1;
        end
      end
      WRITE: begin
        if (abort_in) begin
          state_next = IDLE;
          error_set  = 1'b1;
        end else if (addr == LAST_ADDR) begin
          state_next = DONE;
        end else begin
          state_next = COLLECT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx      <= 2'd0;
      addr     <= '0;
      sample   <= '0;
      idle_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= error_set;
      case (state)
        IDLE: begin
          if (start_in) begin
            addr     <= '0;
            idx      <= 2'd0;
            idle_cnt <= '0;
          end
        end
        COLLECT: begin
          if (!abort_in) begin
            if (accept) begin
              case (idx)
                2'd0:    sample[7:0]   <= byte_in;
                2'd1:    sample[15:8]  <= byte_in;
                default: sample[23:16] <= byte_in;
              endcase
              idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          // The quiet-cycle count restarts for each new sample.
          idle_cnt <= '0;
          // The address stops at the last entry, so it never wraps
          // and stays visible during DONE.
          if (!abort_in && addr != LAST_ADDR) addr <= addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_loader.sv
// Testbench for waveform_loader. A transaction-level model predicts the
// handshake, write, done and error behaviour on every cycle. Directed
// literal checks pin packing, latency, abort, timeout and reset behaviour.
module tb_waveform_loader;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int SW    = 24;
  localparam int TO    = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          byte_valid_in = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_ready_out;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [SW-1:0] wr_data_out;
  logic          busy_out;
  logic          done_out;
  logic          error_out;

  always #5 clk_in = ~clk_in;

  waveform_loader #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .abort_in(abort_in),
    .byte_valid_in(byte_valid_in), .byte_in(byte_in),
    .byte_ready_out(byte_ready_out), .wr_en_out(wr_en_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: which phase the loader must be in and what it holds.
  bit         m_collect, m_write, m_done, m_err, n_done, n_err;
  int         m_addr, m_quiet;
  logic [7:0] m_part[$];
  logic [23:0] m_data;

  initial forever begin
    @(posedge clk_in or posedge rst_in);
    if (rst_in) begin
      m_collect = 0; m_write = 0; m_done = 0; m_err = 0;
      m_addr = 0; m_quiet = 0; m_part.delete();
    end else begin
      n_done = 0; n_err = 0;
      if (m_write) begin
        m_write = 0;
        if (abort_in) n_err = 1;
        else if (m_addr == DEPTH - 1) n_done = 1;
        else begin m_addr++; m_collect = 1; m_quiet = 0; end
      end else if (m_collect) begin
        if (abort_in) begin
          m_collect = 0; n_err = 1;
        end else if (byte_valid_in) begin
          m_part.push_back(byte_in);
          m_quiet = 0;
          if (m_part.size() == 3) begin
            m_data = {m_part[2], m_part[1], m_part[0]};
            m_part.delete();
            m_collect = 0; m_write = 1;
          end
        end else if (m_quiet == TO - 1) begin
          m_collect = 0; n_err = 1;
        end else begin
          m_quiet++;
        end
      end else if (!m_done && start_in) begin
        m_collect = 1; m_addr = 0; m_quiet = 0; m_part.delete();
      end
      m_done = n_done;
      m_err  = n_err;
    end
  end

  // Per-cycle compare and write capture.
  logic [23:0] ram [DEPTH];
  int          ram_tag [DEPTH];
  int          load_id = 0;
  int          cyc = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int          last511_cyc = 0, done_cyc = 0, last_addr = 0;
  logic [23:0] last_data = '0;

  initial forever begin
    @(negedge clk_in);
    cyc++;
    check("ready", 32'(byte_ready_out), 32'(m_collect));
    check("wr_en", 32'(wr_en_out), 32'(m_write));
    check("busy", 32'(busy_out), 32'(m_collect | m_write));
    check("done", 32'(done_out), 32'(m_done));
    check("error", 32'(error_out), 32'(m_err));
    if (m_write) begin
      check("wr_addr", 32'(wr_addr_out), 32'(m_addr));
      check("wr_data", 32'(wr_data_out), 32'(m_data));
    end
    if (m_done) check("done_addr", 32'(wr_addr_out), 32'(DEPTH - 1));
    if (wr_en_out) begin
      ram[wr_addr_out]     = wr_data_out;
      ram_tag[wr_addr_out] = load_id;
      wr_cnt++;
      last_addr = int'(wr_addr_out);
      last_data = wr_data_out;
      if (int'(wr_addr_out) == DEPTH - 1) last511_cyc = cyc;
    end
    if (done_out) begin done_cnt++; done_cyc = cyc; end
    if (error_out) err_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit r, got;
    got = 0;
    byte_in = b;
    byte_valid_in = 1'b1;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk_in);
      r = byte_ready_out;
      @(posedge clk_in); #1;
      got = r;
    end
    byte_valid_in = 1'b0;
    if (!got) check("handshake_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_table(input int max_gap);
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < 3; j++) begin
        send_byte(8'(i + j));
        if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
      end
    end
  endtask

  task automatic check_ram(input string name);
    int bad, first;
    logic [23:0] exp;
    bad = 0; first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = {8'(i + 2), 8'(i + 1), 8'(i)};
      if (ram_tag[i] != load_id || ram[i] !== exp) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("first bad address %0d", first);
    check(name, 32'(bad), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, 32'({byte_ready_out, wr_en_out, busy_out, done_out, error_out}), 32'd0);
    check({name, "_addr"}, 32'(wr_addr_out), 32'd0);
    check({name, "_data"}, 32'(wr_data_out), 32'd0);
  endtask

  int w0, d0, e0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_idle_outputs("reset_outputs");
    rst_in = 1'b0;
    idle(2);

    // Packing and latency
    pulse_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("pack_wr_en", 32'(wr_en_out), 32'd1);
    check("pack_addr", 32'(wr_addr_out), 32'd0);
    check("pack_data", 32'(wr_data_out), 32'h332211);
    check("pack_ready", 32'(byte_ready_out), 32'd0);

    // A start during COLLECT is ignored
    send_byte(8'h44);
    pulse_start();
    send_byte(8'h55); send_byte(8'h66);
    check("restart_ignored_addr", 32'(wr_addr_out), 32'd1);
    check("restart_ignored_data", 32'(wr_data_out), 32'h665544);

    // An abort together with a valid byte drops the byte
    send_byte(8'h77);
    abort_in = 1'b1; byte_valid_in = 1'b1; byte_in = 8'h88;
    @(posedge clk_in); #1;
    abort_in = 1'b0; byte_valid_in = 1'b0;
    check("abort_error", 32'(error_out), 32'd1);
    check("abort_busy", 32'(busy_out), 32'd0);
    idle(5);
    check("abort_writes", 32'(wr_cnt), 32'd2);
    check("abort_err_cnt", 32'(err_cnt), 32'd1);

    // Full gapless load
    load_id = 1;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    send_table(0);
    idle(5);
    check("full_writes", 32'(wr_cnt - w0), 32'd512);
    check("full_done", 32'(done_cnt - d0), 32'd1);
    check("full_errors", 32'(err_cnt - e0), 32'd0);
    check("full_done_lat", 32'(done_cyc - last511_cyc), 32'd1);
    check("full_busy", 32'(busy_out), 32'd0);
    check_ram("full_ram");

    // Load with gaps shorter than the timeout
    load_id = 2;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    pulse_start();
    send_table(12);
    idle(5);
    check("gap_writes", 32'(wr_cnt - w0), 32'd512);
    check("gap_done", 32'(done_cnt - d0), 32'd1);
    check("gap_errors", 32'(err_cnt - e0), 32'd0);
    check_ram("gap_ram");

    // Timeout after a partial second sample
    w0 = wr_cnt; e0 = err_cnt;
    pulse_start();
    send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    idle(20);
    check("to_writes", 32'(wr_cnt - w0), 32'd1);
    check("to_addr", 32'(last_addr), 32'd0);
    check("to_data", 32'(last_data), 32'hA2A1A0);
    check("to_errors", 32'(err_cnt - e0), 32'd1);
    check("to_busy", 32'(busy_out), 32'd0);
    pulse_start();
    send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2);
    check("to_restart_addr", 32'(wr_addr_out), 32'd0);
    check("to_restart_data", 32'(wr_data_out), 32'hB2B1B0);
    idle(20);

    // Asynchronous reset in the middle of a load
    pulse_start();
    for (int k = 0; k < 300; k++) send_byte(8'(k));
    idle(2);
    check("midload_addr", 32'(wr_addr_out), 32'd100);
    check("midload_busy", 32'(busy_out), 32'd1);
    #1 rst_in = 1'b1;
    #1 check_idle_outputs("async_reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    w0 = wr_cnt;
    byte_valid_in = 1'b1; byte_in = 8'h5A;
    idle(10);
    byte_valid_in = 1'b0;
    check("post_reset_writes", 32'(wr_cnt - w0), 32'd0);
    pulse_start();
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
    check("post_reset_addr", 32'(wr_addr_out), 32'd0);
    check("post_reset_data", 32'(wr_data_out), 32'hC2C1C0);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
